// File: rtl/ila_pattern_gen.sv
// ila_pattern_gen
// ----------------------------------------------------------------------------
// Purpose: This module generates a deterministic pattern that drives the ILA
// sample bus. It is used in simulation and during on-board bring-up.
// - The pattern advances on each enabled cycle, using one of these modes:
//   up-count, down-count, Fibonacci LFSR, walking-one or hold.
// - The up and down counts use a programmable step and an optional wrap limit.
// - A one-cycle wrap pulse marks each pattern wrap.
// - A one-cycle match trigger marks entry into a chosen value.
//
// Optional build macro: ILA_PATTERN_GRAY_EN
//   When defined, mode 5 runs an internal binary up-counter and outputs its
//   Gray code. When undefined, mode 5 is a hold and the counter is not built.
//
// Ports:
//   clk            in   sole clock
//   ILA_rst        in   synchronous active-high reset
//   en             in   advance the pattern when high
//   mode           in   0 up, 1 down, 2 LFSR, 3 walking-one, 4 hold,
//                       5 Gray (macro only), 6-7 reserved (hold)
//   step           in   increment/decrement amount for modes 0/1
//   load           in   synchronous load strobe (takes priority over en)
//   load_val       in   value loaded on load
//   limit          in   wrap limit for modes 0/1 (0 = natural 2^WIDTH wrap)
//   trig_val       in   compare value for match_trig
//   ila_sample_dut out  current pattern (registered)
//   led            out  top LED_W bits of the pattern
//   ila_clk_src    out  combinational copy of clk
//   wrap           out  one-cycle pulse, in the same cycle as the wrapped value
//   match_trig     out  one-cycle pulse, one cycle after the pattern first
//                       equals trig_val
module ila_pattern_gen #(
  parameter int               WIDTH     = 25,
  parameter int               LED_W     = 8,
  parameter int               STEP_W    = 4,
  parameter logic [WIDTH-1:0] LFSR_TAPS = 25'h1200000
) (
  input  logic              clk,
  input  logic              ILA_rst,
  input  logic              en,
  input  logic [2:0]        mode,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [WIDTH-1:0]  limit,
  input  logic [WIDTH-1:0]  trig_val,
  output logic [WIDTH-1:0]  ila_sample_dut,
  output logic [LED_W-1:0]  led,
  output logic              ila_clk_src,
  output logic              wrap,
  output logic              match_trig
);

  localparam logic [2:0] MODE_UP   = 3'd0;
  localparam logic [2:0] MODE_DOWN = 3'd1;
  localparam logic [2:0] MODE_LFSR = 3'd2;
  localparam logic [2:0] MODE_WALK = 3'd3;
  localparam logic [2:0] MODE_HOLD = 3'd4;
`ifdef ILA_PATTERN_GRAY_EN
  localparam logic [2:0] MODE_GRAY = 3'd5;
`endif

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   ZERO_EXT_C = {(WIDTH+1){1'b0}};

  logic [WIDTH-1:0] value_r;
  logic [WIDTH-1:0] value_next_s;
  logic             wrap_r;
  logic             wrap_next_s;
  logic             match_trig_r;
  logic             eq_prev_r;
  logic             eq_s;

  logic [WIDTH:0]   step_ext_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] lfsr_next_s;
  logic [WIDTH-1:0] walk_next_s;
  logic             walk_onehot_s;

`ifdef ILA_PATTERN_GRAY_EN
  logic [WIDTH-1:0] bin_r;
  logic [WIDTH-1:0] bin_next_s;
  logic [WIDTH-1:0] bin_inc_s;
`endif

  // Candidate next values for the arithmetic and shift modes.
  always_comb begin
    // The sum is computed one bit wider, so the carry out is visible as the natural wrap.
    step_ext_s    = {{(WIDTH+1-STEP_W){1'b0}}, step};
    sum_s         = {1'b0, value_r} + step_ext_s;
    diff_s        = value_r - step_ext_s[WIDTH-1:0];
    walk_onehot_s = (value_r != ZERO_C) && ((value_r & (value_r - ONE_C)) == ZERO_C);
    // The all-zero state is the LFSR lock-up state, so restart the sequence from 1.
    if (value_r == ZERO_C) begin
      lfsr_next_s = ONE_C;
    end else begin
      lfsr_next_s = {value_r[WIDTH-2:0], ^(value_r & LFSR_TAPS)};
    end
    // A corrupted walking-one pattern, including 0, restarts at bit 0.
    if (walk_onehot_s) begin
      walk_next_s = {value_r[WIDTH-2:0], value_r[WIDTH-1]};
    end else begin
      walk_next_s = ONE_C;
    end
`ifdef ILA_PATTERN_GRAY_EN
    bin_inc_s = bin_r + ONE_C;
`endif
  end

  // Next-state selection. Load has priority over en, and en has priority over hold.
  always_comb begin
    value_next_s = value_r;
    wrap_next_s  = 1'b0;
`ifdef ILA_PATTERN_GRAY_EN
    bin_next_s   = bin_r;
`endif
    if (load) begin
      value_next_s = load_val;
`ifdef ILA_PATTERN_GRAY_EN
      bin_next_s   = load_val;
`endif
    end else if (en) begin
      case (mode)
        MODE_UP: begin
          if (step_ext_s == ZERO_EXT_C) begin
            value_next_s = value_r;
          end else if ((limit != ZERO_C) && (sum_s > {1'b0, limit})) begin
            value_next_s = ZERO_C;
            wrap_next_s  = 1'b1;
          end else if ((limit == ZERO_C) && sum_s[WIDTH]) begin
            value_next_s = sum_s[WIDTH-1:0];
            wrap_next_s  = 1'b1;
          end else begin
            value_next_s = sum_s[WIDTH-1:0];
          end
        end
        MODE_DOWN: begin
          // On underflow, reload from the limit when a limit is set; otherwise wrap modulo 2^WIDTH.
          if (step_ext_s > {1'b0, value_r}) begin
            wrap_next_s = 1'b1;
            if (limit != ZERO_C) begin
              value_next_s = limit;
            end else begin
              value_next_s = diff_s;
            end
          end else begin
            value_next_s = diff_s;
          end
        end
        MODE_LFSR: begin
          value_next_s = lfsr_next_s;
          wrap_next_s  = (lfsr_next_s == ONE_C);
        end
        MODE_WALK: begin
          value_next_s = walk_next_s;
          wrap_next_s  = walk_onehot_s & value_r[WIDTH-1];
        end
`ifdef ILA_PATTERN_GRAY_EN
        MODE_GRAY: begin
          bin_next_s   = bin_inc_s;
          value_next_s = bin_inc_s ^ {1'b0, bin_inc_s[WIDTH-1:1]};
          wrap_next_s  = (bin_r == {WIDTH{1'b1}});
        end
`endif
        MODE_HOLD: begin
          value_next_s = value_r;
        end
        default: begin
          value_next_s = value_r;
        end
      endcase
    end else begin
      value_next_s = value_r;
    end
  end

  // Current equality between the pattern and the trigger value.
  always_comb begin
    eq_s = (value_r == trig_val);
  end

  // Pattern, wrap and trigger registers. The trigger fires only when equality is newly entered.
  always_ff @(posedge clk) begin
    if (ILA_rst) begin
      value_r      <= ZERO_C;
      wrap_r       <= 1'b0;
      match_trig_r <= 1'b0;
      eq_prev_r    <= 1'b0;
    end else begin
      value_r      <= value_next_s;
      wrap_r       <= wrap_next_s;
      match_trig_r <= eq_s & ~eq_prev_r;
      eq_prev_r    <= eq_s;
    end
  end

`ifdef ILA_PATTERN_GRAY_EN
  // Binary count behind the Gray output. It changes only in mode 5 or on load.
  always_ff @(posedge clk) begin
    if (ILA_rst) begin
      bin_r <= ZERO_C;
    end else begin
      bin_r <= bin_next_s;
    end
  end
`endif

  assign ila_sample_dut = value_r;
  assign led            = value_r[WIDTH-1 -: LED_W];
  assign ila_clk_src    = clk;
  assign wrap           = wrap_r;
  assign match_trig     = match_trig_r;

endmodule

// File: tb/tb_ila_pattern_gen.sv
module tb_ila_pattern_gen;
  localparam int W   = 8;
  localparam int LW  = 4;
  localparam int SW  = 4;
  localparam int MOD = 256;
  localparam logic [W-1:0] TAPS = 8'hB8;   // x^8+x^6+x^5+x^4+1

  logic          clk = 1'b0;
  logic          ila_rst;
  logic          en;
  logic [2:0]    mode;
  logic [SW-1:0] step;
  logic          load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  limit;
  logic [W-1:0]  trig_val;
  logic [W-1:0]  ila_sample_dut;
  logic [LW-1:0] led;
  logic          ila_clk_src;
  logic          wrap;
  logic          match_trig;

  int errors = 0;
  int checks = 0;

  // Reference model state. Integers follow the behavioural rules directly.
  int m_val = 0;
  int m_bin = 0;
  bit m_wrap = 1'b0;
  bit m_match = 1'b0;
  bit m_prev_eq = 1'b0;

  ila_pattern_gen #(.WIDTH(W), .LED_W(LW), .STEP_W(SW), .LFSR_TAPS(TAPS)) dut (
    .clk(clk), .ILA_rst(ila_rst), .en(en), .mode(mode), .step(step),
    .load(load), .load_val(load_val), .limit(limit), .trig_val(trig_val),
    .ila_sample_dut(ila_sample_dut), .led(led), .ila_clk_src(ila_clk_src),
    .wrap(wrap), .match_trig(match_trig)
  );

  always #5 clk = ~clk;

  // Advance one clock edge, update the model from the inputs seen at that edge, then settle.
  task automatic tick();
    int nv;
    int s;
    bit nw;
    bit eq;
    @(posedge clk);
    eq = (m_val == int'(trig_val));
    if (ila_rst) begin
      m_val = 0; m_wrap = 1'b0; m_match = 1'b0; m_prev_eq = 1'b0; m_bin = 0;
    end else begin
      m_match   = eq && !m_prev_eq;
      m_prev_eq = eq;
      nv = m_val;
      nw = 1'b0;
      if (load) begin
        nv = int'(load_val);
        m_bin = int'(load_val);
      end else if (en) begin
        case (mode)
          3'd0: if (int'(step) != 0) begin
            s = m_val + int'(step);
            if (int'(limit) != 0 && s > int'(limit)) begin nv = 0; nw = 1'b1; end
            else if (int'(limit) == 0 && s >= MOD) begin nv = s - MOD; nw = 1'b1; end
            else nv = s;
          end
          3'd1: if (int'(step) > m_val) begin
            nw = 1'b1;
            nv = (int'(limit) != 0) ? int'(limit) : m_val - int'(step) + MOD;
          end else nv = m_val - int'(step);
          3'd2: begin
            nv = (m_val == 0) ? 1 : ((m_val * 2) % MOD) + ($countones(m_val & int'(TAPS)) % 2);
            nw = (nv == 1);
          end
          3'd3: if ($countones(m_val) == 1) begin
            nw = (m_val == MOD / 2);
            nv = nw ? 1 : m_val * 2;
          end else nv = 1;
`ifdef ILA_PATTERN_GRAY_EN
          3'd5: begin
            nw = (m_bin == MOD - 1);
            m_bin = (m_bin + 1) % MOD;
            nv = m_bin ^ (m_bin / 2);
          end
`endif
          default: nv = m_val;
        endcase
      end
      m_val  = nv;
      m_wrap = nw;
    end
    #1;
  endtask

  task automatic test_reset();
    ila_rst = 1'b1; en = 1'b1; mode = 3'd0; step = 4'd5; load = 1'b1;
    load_val = 8'h5A; limit = 8'd0; trig_val = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ila_sample_dut !== 8'd0) begin errors++; $display("FAIL reset_value got=%0h want=0", ila_sample_dut); end
      checks++; if (wrap !== 1'b0 || match_trig !== 1'b0) begin errors++; $display("FAIL reset_flags got wrap=%b match=%b want 0/0", wrap, match_trig); end
      checks++; if (led !== 4'd0) begin errors++; $display("FAIL reset_led got=%0h want=0", led); end
    end
    checks++; if (ila_clk_src !== 1'b1) begin errors++; $display("FAIL clk_src_high got=%b want=1", ila_clk_src); end
    #5;
    checks++; if (ila_clk_src !== 1'b0) begin errors++; $display("FAIL clk_src_low got=%b want=0", ila_clk_src); end
    ila_rst = 1'b0; load = 1'b0;
  endtask

  task automatic test_up_natural();
    int wraps = 0;
    en = 1'b1; mode = 3'd0; step = 4'd1; limit = 8'd0; load = 1'b0;
    for (int i = 1; i <= 258; i++) begin
      tick();
      checks++; if (ila_sample_dut !== W'(i % MOD)) begin errors++; $display("FAIL up_value i=%0d got=%0d want=%0d", i, ila_sample_dut, i % MOD); end
      checks++; if (wrap !== (i == MOD)) begin errors++; $display("FAIL up_wrap i=%0d got=%b want=%b", i, wrap, i == MOD); end
      checks++; if (led !== LW'((i % MOD) >> (W - LW))) begin errors++; $display("FAIL up_led i=%0d got=%0h want=%0h", i, led, (i % MOD) >> (W - LW)); end
      checks++; if (match_trig !== m_match) begin errors++; $display("FAIL up_match i=%0d got=%b want=%b", i, match_trig, m_match); end
      if (wrap === 1'b1) wraps++;
    end
    checks++; if (wraps != 1) begin errors++; $display("FAIL up_wrap_count got=%0d want=1", wraps); end
  endtask

  task automatic test_limit();
    int up_v[4] = '{3, 6, 9, 0};
    int dn_v[3] = '{5, 1, 10};
    load = 1'b1; load_val = 8'd0; tick(); load = 1'b0;
    mode = 3'd0; step = 4'd3; limit = 8'd10;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (ila_sample_dut !== W'(up_v[i]) || wrap !== (i == 3)) begin errors++; $display("FAIL limit_up i=%0d got=%0d/%b want=%0d/%b", i, ila_sample_dut, wrap, up_v[i], i == 3); end
    end
    load = 1'b1; load_val = 8'd9; tick(); load = 1'b0;
    mode = 3'd1; step = 4'd4;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ila_sample_dut !== W'(dn_v[i]) || wrap !== (i == 2)) begin errors++; $display("FAIL limit_down i=%0d got=%0d/%b want=%0d/%b", i, ila_sample_dut, wrap, dn_v[i], i == 2); end
    end
    // Value already above the limit wraps to 0 on the next up step.
    load = 1'b1; load_val = 8'd200; tick(); load = 1'b0;
    mode = 3'd0; step = 4'd1; tick();
    checks++; if (ila_sample_dut !== 8'd0 || wrap !== 1'b1) begin errors++; $display("FAIL above_limit got=%0d/%b want=0/1", ila_sample_dut, wrap); end
    // A zero step holds the value, with no wrap.
    step = 4'd0; tick(); tick();
    checks++; if (ila_sample_dut !== 8'd0 || wrap !== 1'b0) begin errors++; $display("FAIL step_zero got=%0d/%b want=0/0", ila_sample_dut, wrap); end
  endtask

  task automatic test_lfsr();
    bit seen[MOD];
    int distinct = 0;
    int wraps = 0;
    load = 1'b1; load_val = 8'd0; tick(); load = 1'b0;
    mode = 3'd2; tick();
    checks++; if (ila_sample_dut !== 8'd1 || wrap !== 1'b1) begin errors++; $display("FAIL lfsr_lockup got=%0d/%b want=1/1", ila_sample_dut, wrap); end
    for (int i = 0; i < MOD; i++) seen[i] = 1'b0;
    for (int i = 0; i < 255; i++) begin
      tick();
      checks++; if (ila_sample_dut !== W'(m_val) || wrap !== m_wrap) begin errors++; $display("FAIL lfsr_step i=%0d got=%0h/%b want=%0h/%b", i, ila_sample_dut, wrap, m_val, m_wrap); end
      if (!seen[ila_sample_dut]) begin seen[ila_sample_dut] = 1'b1; distinct++; end
      if (wrap === 1'b1) wraps++;
    end
    checks++; if (ila_sample_dut !== 8'd1) begin errors++; $display("FAIL lfsr_period got=%0h want=1", ila_sample_dut); end
    checks++; if (wraps != 1 || distinct != 255) begin errors++; $display("FAIL lfsr_cover got wraps=%0d states=%0d want 1/255", wraps, distinct); end
  endtask

  task automatic test_walk();
    load = 1'b1; load_val = 8'h05; tick(); load = 1'b0;
    mode = 3'd3;
    for (int i = 0; i <= 8; i++) begin
      tick();
      checks++; if (ila_sample_dut !== W'((i == 8) ? 1 : (1 << i)) || wrap !== (i == 8)) begin errors++; $display("FAIL walk i=%0d got=%0h/%b want=%0h/%b", i, ila_sample_dut, wrap, (i == 8) ? 1 : (1 << i), i == 8); end
    end
    tick();
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (ila_sample_dut !== 8'd2 || wrap !== 1'b0) begin errors++; $display("FAIL en_hold i=%0d got=%0h/%b want=2/0", i, ila_sample_dut, wrap); end
    end
    en = 1'b1;
  endtask

  task automatic test_match();
    trig_val = 8'd7;
    load = 1'b1; load_val = 8'd0; tick(); load = 1'b0;
    mode = 3'd0; step = 4'd1; limit = 8'd0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      checks++; if (match_trig !== 1'b0) begin errors++; $display("FAIL match_early i=%0d got=%b want=0", i, match_trig); end
    end
    mode = 3'd4;
    tick();
    checks++; if (match_trig !== 1'b1 || ila_sample_dut !== 8'd7) begin errors++; $display("FAIL match_pulse got=%b/%0d want=1/7", match_trig, ila_sample_dut); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (match_trig !== 1'b0) begin errors++; $display("FAIL match_single i=%0d got=%b want=0", i, match_trig); end
    end
    mode = 3'd0; tick(); tick(); tick();
    ila_rst = 1'b1; tick(); ila_rst = 1'b0;
    checks++; if (ila_sample_dut !== 8'd0 || match_trig !== 1'b0 || wrap !== 1'b0) begin errors++; $display("FAIL mid_reset got=%0d/%b/%b want=0/0/0", ila_sample_dut, match_trig, wrap); end
  endtask

  task automatic test_gray();
`ifdef ILA_PATTERN_GRAY_EN
    int g_v[7] = '{1, 3, 2, 6, 7, 5, 4};
    logic [W-1:0] prev;
    int wraps = 0;
    ila_rst = 1'b1; tick(); ila_rst = 1'b0;
    mode = 3'd5; en = 1'b1;
    prev = ila_sample_dut;
    for (int i = 0; i < MOD; i++) begin
      tick();
      if (i < 7) begin
        checks++; if (ila_sample_dut !== W'(g_v[i])) begin errors++; $display("FAIL gray_seq i=%0d got=%0d want=%0d", i, ila_sample_dut, g_v[i]); end
      end
      checks++; if ($countones(prev ^ ila_sample_dut) != 1 || wrap !== (i == MOD - 1)) begin errors++; $display("FAIL gray_step i=%0d got=%0h/%b prev=%0h wrap_want=%b", i, ila_sample_dut, wrap, prev, i == MOD - 1); end
      if (wrap === 1'b1) wraps++;
      prev = ila_sample_dut;
    end
    checks++; if (wraps != 1 || ila_sample_dut !== 8'd0) begin errors++; $display("FAIL gray_wrap got wraps=%0d val=%0h want 1/0", wraps, ila_sample_dut); end
`else
    load = 1'b1; load_val = 8'h3C; tick(); load = 1'b0;
    mode = 3'd5; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (ila_sample_dut !== 8'h3C || wrap !== 1'b0) begin errors++; $display("FAIL mode5_hold i=%0d got=%0h/%b want=3c/0", i, ila_sample_dut, wrap); end
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      ila_rst  = ($urandom_range(0, 199) == 0);
      load     = ($urandom_range(0, 24) == 0);
      load_val = W'($urandom);
      en       = ($urandom_range(0, 9) != 0);
      if ((i % 24) == 0) mode = 3'($urandom);
      step     = SW'($urandom);
      if ((i % 40) == 0) limit = ($urandom_range(0, 2) == 0) ? 8'd0 : W'($urandom);
      trig_val = W'($urandom_range(0, 15));
      tick();
      checks++; if (ila_sample_dut !== W'(m_val)) begin errors++; $display("FAIL rand_value i=%0d mode=%0d got=%0h want=%0h", i, mode, ila_sample_dut, m_val); end
      checks++; if (wrap !== m_wrap) begin errors++; $display("FAIL rand_wrap i=%0d mode=%0d got=%b want=%b", i, mode, wrap, m_wrap); end
      checks++; if (match_trig !== m_match) begin errors++; $display("FAIL rand_match i=%0d got=%b want=%b", i, match_trig, m_match); end
      checks++; if (led !== LW'(m_val >> (W - LW))) begin errors++; $display("FAIL rand_led i=%0d got=%0h want=%0h", i, led, m_val >> (W - LW)); end
    end
    ila_rst = 1'b0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_natural();
    test_limit();
    test_lfsr();
    test_walk();
    test_match();
    test_gray();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
